// File: rtl/sdbp_frame_tx.sv
// sdbp_frame_tx: double-buffered LED frame capture and serial transmitter.
// A capture window fills the write bank while the read bank is shifted out
// MSB first on sclk/sdo, followed by a lat pulse. The banks swap in IDLE
// whenever a completed frame is waiting.
module sdbp_frame_tx #(
  parameter int NUM_LED    = 360,
  parameter int HALF_DIV   = 2,
  parameter int LAT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdbpflag,
  input  logic [15:0] wtdina,
  input  logic [9:0]  wtaddr,
  output logic        sclk,
  output logic        sdo,
  output logic        lat,
  output logic        busy,
  output logic        frame_drop
);

  localparam int IW = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
  localparam int DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int LW = (LAT_CYCLES > 1) ? $clog2(LAT_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_LED - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(HALF_DIV - 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'(LAT_CYCLES - 1);
  localparam logic [9:0]    CLOSE_ADDR = 10'(NUM_LED);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t          state, state_nxt;
  logic [15:0]     mem [2][NUM_LED];
  logic            flag_q, win_open, frame_ready, bank_sel;
  logic [DW-1:0]   div_cnt;
  logic [3:0]      bit_cnt;
  logic [IW-1:0]   word_idx;
  logic [LW-1:0]   lat_cnt;
  logic [15:0]     sh;
  logic [15:0]     nxt;

  logic            flag_rise, wr_en, close, swap;
  logic            div_tick, fall, word_end, frame_end;
  logic            rd_bank;
  logic [IW-1:0]   rd_idx;
  logic [15:0]     rd_word;

  assign flag_rise = sdbpflag & ~flag_q;
  assign wr_en     = win_open && (wtaddr < CLOSE_ADDR);
  assign close     = win_open && (wtaddr == CLOSE_ADDR);
  assign swap      = (state == IDLE) && frame_ready;
  assign div_tick  = (div_cnt == DIV_LAST);
  assign fall      = (state == SHIFT) && div_tick && sclk;
  assign word_end  = fall && (bit_cnt == 4'd15);
  assign frame_end = word_end && (word_idx == LAST_IDX);

  // In IDLE the about-to-become read bank is looked at so word 0 can be
  // loaded on the swap edge; in SHIFT the following word is prefetched.
  assign rd_bank = (state == SHIFT) ? bank_sel : ~bank_sel;
  assign rd_idx  = ((state == SHIFT) && (word_idx != LAST_IDX)) ? word_idx + 1'b1 : '0;
  assign rd_word = mem[rd_bank][rd_idx];

  // Capture window control, frame-ready flag and overwrite detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q      <= 1'b0;
      win_open    <= 1'b0;
      frame_ready <= 1'b0;
      frame_drop  <= 1'b0;
    end else begin
      flag_q <= sdbpflag;
      if (flag_rise)  win_open <= 1'b1;
      else if (close) win_open <= 1'b0;
      if (close)     frame_ready <= 1'b1;
      else if (swap) frame_ready <= 1'b0;
      frame_drop <= close && frame_ready && !swap;
    end
  end

  // Write port of the capture bank (the bank not selected for transmit).
  always_ff @(posedge clk) begin
    if (wr_en) mem[~bank_sel][wtaddr[IW-1:0]] <= wtdina;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and decoded outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    lat       = 1'b0;
    sdo       = 1'b0;
    case (state)
      IDLE: begin
        if (frame_ready) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        sdo  = sh[15];
        if (frame_end) state_nxt = LATCH;
      end
      LATCH: begin
        busy = 1'b1;
        lat  = 1'b1;
        if (lat_cnt == LAT_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bank select, sclk divider and bit/word/latch counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel <= 1'b0;
      sclk     <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      word_idx <= '0;
      lat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          sclk <= 1'b0;
          if (swap) begin
            bank_sel <= ~bank_sel;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            word_idx <= '0;
            lat_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (div_tick) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (fall) begin
              if (word_end) begin
                bit_cnt  <= '0;
                word_idx <= word_idx + 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: lat_cnt <= lat_cnt + 1'b1;
        default: sclk <= 1'b0;
      endcase
    end
  end

  // Output shifter: word 0 loads on the swap edge, later words come from
  // the prefetch register, and bits advance only on sclk falling edges.
  always_ff @(posedge clk) begin
    nxt <= rd_word;
    if (swap)      sh <= rd_word;
    else if (fall) sh <= word_end ? nxt : {sh[14:0], 1'b0};
  end

endmodule

// File: doc/sdbp_frame_tx.md
SDBP_FRAME_TX -- requirements
Module: sdbp_frame_tx

Interface
REQ-001 SHALL have parameter NUM_LED, default 360, LED words per frame.
REQ-002 SHALL have parameter HALF_DIV, default 2, clk cycles per sclk half-period (min 1).
REQ-003 SHALL have parameter LAT_CYCLES, default 4, clk cycles lat is held high.
REQ-004 SHALL have port clk  input  1  system clock (25 MHz); one clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sdbpflag  input  1  frame-start strobe from the frame generator.
REQ-007 SHALL have port wtdina  input  16  LED brightness word.
REQ-008 SHALL have port wtaddr  input  10  LED index for wtdina.
REQ-009 SHALL have port sclk  output  1  serial clock to the LED driver.
REQ-010 SHALL have port sdo  output  1  serial data, MSB first.
REQ-011 SHALL have port lat  output  1  latch pulse after a full frame.
REQ-012 SHALL have port busy  output  1  high while FSM not IDLE.
REQ-013 SHALL have port frame_drop  output  1  one-cycle pulse when an unsent ready frame is overwritten.

Function
REQ-014 SHALL hold two NUM_LED x 16 banks: write bank (capture) and read bank (transmit), swapped by one bank-select bit.
REQ-015 SHALL detect the sdbpflag rising edge (registered previous value) and open the capture window in the following cycle; a rising edge while the window is already open restarts it with no close.
REQ-016 SHALL, each cycle with the window open and wtaddr < NUM_LED, write wtdina to write_bank[wtaddr]; repeated writes to one address: last wins.
REQ-017 SHALL close the window on the first cycle with the window open and wtaddr == NUM_LED (no write), then set frame_ready; wtaddr > NUM_LED is ignored and does not close.
REQ-018 SHALL, if a close occurs while frame_ready is already 1, pulse frame_drop for exactly one cycle and keep frame_ready = 1 (newest data in write bank wins).
REQ-019 SHALL implement FSM IDLE -> SHIFT -> LATCH -> IDLE.
REQ-020 IDLE: if frame_ready, toggle bank select, clear frame_ready, enter SHIFT next cycle; sclk = 0, sdo = 0, lat = 0.
REQ-021 Close and IDLE-swap in the same cycle: swap uses the previously ready frame only; the new close sets frame_ready again with no frame_drop.
REQ-022 SHIFT: sclk starts 0 and toggles every HALF_DIV clk cycles; sdo SHALL be valid at least one clk cycle before each sclk rising edge and change only in the cycle of a falling edge.
REQ-023 SHIFT: words sent in index order 0..NUM_LED-1, bits 15..0 per word; exactly 16*NUM_LED rising edges per frame; internal read latency is hidden from sdo.
REQ-024 SHALL, after the falling edge following the last rising edge, force sclk = 0, sdo = 0 and enter LATCH.
REQ-025 LATCH: lat = 1 for exactly LAT_CYCLES consecutive cycles, then IDLE.
REQ-026 Frame length (HALF_DIV=2, NUM_LED=360): 23040 clk in SHIFT, well under the 420001-cycle sdbpflag period.
REQ-027 busy SHALL be 1 in SHIFT and LATCH, 0 in IDLE.
REQ-028 Capture into the write bank SHALL proceed concurrently with SHIFT from the read bank without corrupting the read bank.

Reset
REQ-029 On rst_n low: FSM IDLE, sclk = 0, sdo = 0, lat = 0, busy = 0, frame_drop = 0, frame_ready = 0, window closed, bank select 0, all counters 0; bank contents undefined.
REQ-030 Reset asserted mid-SHIFT or mid-LATCH SHALL abort immediately; no lat pulse follows release.
REQ-031 After release, no output activity until a complete capture window closes.

Verification
REQ-032 Reset then sdbpflag pulse, wtaddr 0..360 with wtdina = 16'h0100 + addr -> 5760 sclk rising edges; first word shifted 0000_0001_0000_0000, last word 16'h0267; lat high 4 cycles; busy low after.
REQ-033 Window with all wtdina = 16'hFFFF except addr 23 = 16'h0000 -> sdo 1 for all bits except word 23 bits (positions 368..383) = 0.
REQ-034 Two complete frames while SHIFT in progress -> frame_drop one pulse on second close; next transmitted frame = second frame's data.
REQ-035 rst_n low at sclk rising edge 1000 -> outputs 0 within reset; no lat; fresh frame after release transmits correctly.
REQ-036 wtaddr jumps 0..359 then 361, never 360 -> no frame_ready, no SHIFT, no frame_drop.
REQ-037 HALF_DIV = 1 and LAT_CYCLES = 1 -> sclk period 2 clk, lat 1 cycle, same bit sequence as REQ-032.
